sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 17 +
 rtl/sync_fifo_param_if.sv | 38 +++
 rtl/fifo_ptr_wrap.sv | 31 +++
 rtl/sync_fifo_param.sv | 107 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and the pointer wrap rule used by the FIFO and its pointer counters.
package fifo_pkg;

  // Sticky error flags kept together so they can be cleared and updated as one.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Wrap rule: last index returns to zero, so every index 0..depth-1 is used
  // even when depth is not a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Bundle of the FIFO data/control/status signals; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) ();

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [CNT_W-1:0]      af_th;
  logic [CNT_W-1:0]      ae_th;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  modport master (
    output push, pop, data_in, af_th, ae_th, clr_err,
    input  data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow, wr_ptr, rd_ptr
  );

  modport slave (
    input  push, pop, data_in, af_th, ae_th, clr_err,
    output data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow, wr_ptr, rd_ptr
  );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Storage index counter that wraps from DEPTH-1 back to 0.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Next index: advance with wrap only when incremented.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ADDR_W'(ptr_next(32'(ptr_q), DEPTH));
  end

  // Index register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous show-ahead FIFO with arbitrary depth, count-derived status flags
// and sticky overflow/underflow flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0]      af_th,
  input  logic [CNT_W-1:0]      ae_th,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [ADDR_W-1:0]     rd_ptr
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  err_flags_t            err_q;
  err_flags_t            err_d;
  logic                  push_acc;
  logic                  pop_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A push into a full FIFO still goes through when a pop frees a slot in the same cycle.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  // Occupancy: up on push only, down on pop only.
  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky errors: clear first, then a new error in the same cycle sets it again.
  always_comb begin
    err_d = clr_err ? '0 : err_q;
    if (push && !push_acc) err_d.overflow  = 1'b1;
    if (pop && empty)      err_d.underflow = 1'b1;
  end

  // Occupancy and error state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr] <= data_in;
  end

  // Show-ahead head entry, forced to zero while empty.
  always_comb begin
    data_out = '0;
    if (!empty) data_out = mem_q[rd_ptr];
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= af_th);
  assign almost_empty = (count_q <= ae_th);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule
